// File: rtl/perf_pkg.sv
// Shared definitions for the performance-monitor block: FSM states, event
// channel indices and the location of the free-running cycle channel.
package perf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int EVT_STALL  = 0;
  localparam int EVT_FLUSH  = 1;
  localparam int EVT_RETIRE = 2;
  localparam int EVT_BRANCH = 3;

  // The cycle counter sits directly above the last event channel.
  function automatic int CYC_CH(input int num_evt);
    return num_evt;
  endfunction

endpackage

// File: rtl/perf_cnt_chan.sv
// One counter channel: wrapping or saturating increment with a sticky
// overflow flag. Exposes the post-update value so snapshots see this edge.
module perf_cnt_chan #(
  parameter int CNT_W = 32,
  parameter bit SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt_next,
  output logic             ovf
);

  logic [CNT_W-1:0] cnt;
  logic             ovf_set;

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
    if (&v) return SAT ? v : '0;
    return v + CNT_W'(1);
  endfunction

  always_comb begin
    cnt_next = cnt;
    ovf_set  = 1'b0;
    if (clr) begin
      cnt_next = '0;
    end else if (inc) begin
      cnt_next = bump(cnt);
      ovf_set  = &cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      cnt <= cnt_next;
      if (clr)          ovf <= 1'b0;
      else if (ovf_set) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/perf_counter_unit.sv
// Performance monitor top: run/idle/done FSM, cycle-limit compare, shadow
// snapshot bank and registered read port over NUM_EVT+1 counter channels.
module perf_counter_unit
  import perf_pkg::*;
#(
  parameter int NUM_EVT = 4,
  parameter int CNT_W   = 32,
  parameter bit SAT     = 1'b0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic [NUM_EVT-1:0]           evt_i,
  input  logic [NUM_EVT-1:0]           en_i,
  input  logic                         clr_i,
  input  logic                         snap_i,
  input  logic [CNT_W-1:0]             limit_i,
  input  logic [$clog2(NUM_EVT+1)-1:0] rd_sel_i,
  output logic [CNT_W-1:0]             rd_data_o,
  output logic                         snap_valid_o,
  output logic [NUM_EVT:0]             ovf_o,
  output logic                         done_o
);

  localparam int NCH   = NUM_EVT + 1;
  localparam int CYC   = CYC_CH(NUM_EVT);
  localparam int SEL_W = $clog2(NUM_EVT + 1);

  state_t           state;
  logic             run;
  logic [NCH-1:0]   inc;
  logic [CNT_W-1:0] cnt_next [NCH];
  logic [CNT_W-1:0] shadow   [NCH];
  logic             limit_hit;
  logic             take_snap;

  assign run                = (state == ST_RUN);
  assign inc[NUM_EVT-1:0]   = evt_i & en_i & {NUM_EVT{run}};
  assign inc[CYC]           = run;

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    perf_cnt_chan #(.CNT_W(CNT_W), .SAT(SAT)) u_chan (
      .clk      (clk_i),
      .rst_n    (rst_i),
      .inc      (inc[k]),
      .clr      (clr_i),
      .cnt_next (cnt_next[k]),
      .ovf      (ovf_o[k])
    );
  end

  // Limit is checked against the count this edge produces, so the match edge
  // both stops counting and captures the final totals.
  assign limit_hit = run && (limit_i != '0) && (cnt_next[CYC] == limit_i);
  assign take_snap = !clr_i && ((snap_i && state != ST_DONE) || limit_hit);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= ST_IDLE;
      done_o       <= 1'b0;
      snap_valid_o <= 1'b0;
    end else if (clr_i) begin
      state        <= ST_IDLE;
      done_o       <= 1'b0;
      snap_valid_o <= 1'b0;
    end else begin
      snap_valid_o <= take_snap;
      case (state)
        ST_IDLE: if (start_i) state <= ST_RUN;
        ST_RUN: begin
          if (limit_hit) begin
            state  <= ST_DONE;
            done_o <= 1'b1;
          end else if (!start_i) begin
            state <= ST_IDLE;
          end
        end
        ST_DONE: state <= ST_DONE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int k = 0; k < NCH; k++) shadow[k] <= '0;
    end else if (clr_i) begin
      for (int k = 0; k < NCH; k++) shadow[k] <= '0;
    end else if (take_snap) begin
      for (int k = 0; k < NCH; k++) shadow[k] <= cnt_next[k];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_data_o <= '0;
    end else if (clr_i) begin
      rd_data_o <= '0;
    end else if (rd_sel_i <= SEL_W'(NUM_EVT)) begin
      rd_data_o <= shadow[rd_sel_i];
    end else begin
      rd_data_o <= '0;
    end
  end

endmodule

// File: tb/tb_perf_counter_unit.sv
// Directed bench for perf_counter_unit: a 32-bit instance for limit/snapshot
// behaviour plus 4-bit wrap and saturate instances sharing the same stimulus.
module tb_perf_counter_unit;
  import perf_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  evt;
  logic [3:0]  en;
  logic        clr;
  logic        snap;
  logic [31:0] limit;
  logic [3:0]  limit_s;
  logic [2:0]  rd_sel;

  logic [31:0] rd_data;
  logic        snap_valid;
  logic [4:0]  ovf;
  logic        done;

  logic [3:0]  rd_data_w, rd_data_s;
  logic        snap_valid_w, snap_valid_s;
  logic [4:0]  ovf_w, ovf_s;
  logic        done_w, done_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  perf_counter_unit #(.NUM_EVT(4), .CNT_W(32), .SAT(1'b0)) dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .evt_i(evt), .en_i(en),
    .clr_i(clr), .snap_i(snap), .limit_i(limit), .rd_sel_i(rd_sel),
    .rd_data_o(rd_data), .snap_valid_o(snap_valid), .ovf_o(ovf), .done_o(done)
  );

  perf_counter_unit #(.NUM_EVT(4), .CNT_W(4), .SAT(1'b0)) dut_w (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .evt_i(evt), .en_i(en),
    .clr_i(clr), .snap_i(snap), .limit_i(limit_s), .rd_sel_i(rd_sel),
    .rd_data_o(rd_data_w), .snap_valid_o(snap_valid_w), .ovf_o(ovf_w), .done_o(done_w)
  );

  perf_counter_unit #(.NUM_EVT(4), .CNT_W(4), .SAT(1'b1)) dut_s (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .evt_i(evt), .en_i(en),
    .clr_i(clr), .snap_i(snap), .limit_i(limit_s), .rd_sel_i(rd_sel),
    .rd_data_o(rd_data_s), .snap_valid_o(snap_valid_s), .ovf_o(ovf_s), .done_o(done_s)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; evt = '0; en = 4'hF; clr = 1'b0; snap = 1'b0;
    limit = '0; limit_s = '0; rd_sel = '0;

    // reset state
    tick(3);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_snap_valid", {31'd0, snap_valid}, 0);
    chk("rst_ovf", {27'd0, ovf}, 0);
    chk("rst_done", {31'd0, done}, 0);
    rst_n = 1'b1;
    tick(2);

    // limit run: 30 counted cycles, stall every third cycle
    limit = 32'd30;
    start = 1'b1;
    tick();
    for (int c = 1; c <= 30; c++) begin
      evt = (c % 3 == 0) ? 4'b0001 : 4'b0000;
      tick();
      if (c == 29) chk("done_before_limit", {31'd0, done}, 0);
    end
    chk("done_at_limit", {31'd0, done}, 1);
    chk("auto_snap_valid", {31'd0, snap_valid}, 1);
    evt = '0;
    tick();
    chk("snap_valid_one_pulse", {31'd0, snap_valid}, 0);
    chk("done_held", {31'd0, done}, 1);
    rd_sel = 3'd4;
    tick();
    chk("shadow_cycle_30", rd_data, 30);
    rd_sel = 3'd0;
    tick();
    chk("shadow_ch0_10", rd_data, 10);
    snap = 1'b1;
    tick();
    snap = 1'b0;
    chk("snap_ignored_in_done", {31'd0, snap_valid}, 0);
    chk("done_ignores_start", {31'd0, done}, 1);

    // clear and snapshot together in DONE
    start = 1'b0;
    clr = 1'b1; snap = 1'b1;
    tick();
    clr = 1'b0; snap = 1'b0;
    chk("clr_done", {31'd0, done}, 0);
    chk("clr_no_snap_valid", {31'd0, snap_valid}, 0);
    chk("clr_ovf", {27'd0, ovf}, 0);
    rd_sel = 3'd4;
    tick();
    chk("clr_shadow_cycle", rd_data, 0);
    rd_sel = 3'd0;
    tick();
    chk("clr_shadow_ch0", rd_data, 0);

    // overflow: flush held for 17 counted cycles, then one idle-bound edge
    limit = '0;
    evt = 4'b0010;
    start = 1'b1;
    tick();
    tick(17);
    evt = '0; start = 1'b0;
    tick();
    snap = 1'b1;
    tick();
    snap = 1'b0;
    chk("idle_snap_valid", {31'd0, snap_valid}, 1);
    rd_sel = 3'd1;
    tick();
    chk("ch1_32bit", rd_data, 17);
    chk("ch1_wrap", {28'd0, rd_data_w}, 1);
    chk("ch1_sat", {28'd0, rd_data_s}, 15);
    rd_sel = 3'd4;
    tick();
    chk("cyc_32bit", rd_data, 18);
    chk("cyc_wrap", {28'd0, rd_data_w}, 2);
    chk("cyc_sat", {28'd0, rd_data_s}, 15);
    chk("ovf_32bit", {27'd0, ovf}, 0);
    chk("ovf_wrap", {27'd0, ovf_w}, 32'h12);
    chk("ovf_sat", {27'd0, ovf_s}, 32'h12);
    do_clr();
    chk("ovf_wrap_cleared", {27'd0, ovf_w}, 0);

    // manual snapshot at cycle 7, live count continues
    evt = 4'b0001;
    start = 1'b1;
    tick();
    tick(6);
    snap = 1'b1;
    tick();
    snap = 1'b0;
    chk("snap7_valid", {31'd0, snap_valid}, 1);
    rd_sel = 3'd0;
    tick();
    chk("snap7_data", rd_data, 7);
    chk("snap7_valid_drop", {31'd0, snap_valid}, 0);
    tick();
    snap = 1'b1;
    tick();
    snap = 1'b0;
    tick();
    chk("snap10_data", rd_data, 10);
    snap = 1'b1;
    tick();
    chk("b2b_valid_a", {31'd0, snap_valid}, 1);
    tick();
    chk("b2b_valid_b", {31'd0, snap_valid}, 1);
    snap = 1'b0;
    tick();
    chk("b2b_valid_end", {31'd0, snap_valid}, 0);
    chk("b2b_data", rd_data, 13);
    evt = '0; start = 1'b0;
    tick();
    do_clr();

    // masked channel and start gap
    en = 4'b1011;
    evt = 4'b0100;
    start = 1'b1;
    tick();
    tick(5);
    start = 1'b0;
    tick();
    tick(5);
    snap = 1'b1;
    tick();
    snap = 1'b0;
    rd_sel = 3'd4;
    tick();
    chk("cyc_frozen", rd_data, 6);
    rd_sel = 3'd2;
    tick();
    chk("masked_ch2", rd_data, 0);
    start = 1'b1;
    tick();
    tick(3);
    snap = 1'b1;
    tick();
    snap = 1'b0;
    rd_sel = 3'd4;
    tick();
    chk("cyc_resumed", rd_data, 10);
    rd_sel = 3'd5;
    tick();
    chk("rd_sel_5", rd_data, 0);
    rd_sel = 3'd7;
    tick();
    chk("rd_sel_7", rd_data, 0);

    // asynchronous reset while running
    rd_sel = 3'd4;
    snap = 1'b1;
    tick();
    snap = 1'b0;
    chk("pre_rst_valid", {31'd0, snap_valid}, 1);
    chk("pre_rst_data", rd_data, 10);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_data", rd_data, 0);
    chk("async_rst_valid", {31'd0, snap_valid}, 0);
    chk("async_rst_done", {31'd0, done}, 0);
    chk("async_rst_ovf", {27'd0, ovf}, 0);
    #1 rst_n = 1'b1;
    start = 1'b0;
    tick(2);
    chk("post_rst_shadow", rd_data, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
